// File: rtl/axis_pattern_gen_pkg.sv
// Shared state encodings and PRBS-31 (x^31 + x^28 + 1) constants for axis_pattern_gen.
package axis_pattern_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int unsigned PKTS_W      = 16;
    localparam int unsigned PRBS_W      = 31;
    localparam int unsigned PRBS_TAP_HI = 30;
    localparam int unsigned PRBS_TAP_LO = 27;
    localparam logic [PRBS_W-1:0] PRBS_SEED = '1;

    // One Fibonacci step: feedback bit shifts in at the LSB.
    function automatic logic [PRBS_W-1:0] prbs31_next(input logic [PRBS_W-1:0] s);
        return {s[PRBS_W-2:0], s[PRBS_TAP_HI] ^ s[PRBS_TAP_LO]};
    endfunction

endpackage

// File: rtl/axis_pattern_gen_if.sv
// AXI-Stream bundle used by the pattern generator (master drives, slave returns tready).
interface axis_pattern_gen_if #(
    parameter int unsigned BUS_WIDTH  = 2,
    parameter int unsigned USER_WIDTH = 1,
    parameter int unsigned DEST_WIDTH = 1
) ();
    logic [BUS_WIDTH*8-1:0] tdata;
    logic                   tvalid;
    logic                   tready;
    logic [BUS_WIDTH-1:0]   tkeep;
    logic                   tlast;
    logic [USER_WIDTH-1:0]  tuser;
    logic [DEST_WIDTH-1:0]  tdest;

    modport master (output tdata, tvalid, tkeep, tlast, tuser, tdest, input tready);
    modport slave  (input tdata, tvalid, tkeep, tlast, tuser, tdest, output tready);
endinterface

// File: rtl/axis_pattern_gen_lfsr.sv
// PRBS-31 state register, seeded all-ones; advances one step per asserted step.
// Only instantiated when AXIS_PATTERN_GEN_PRBS_EN is defined.
module axis_pattern_gen_lfsr
    import axis_pattern_gen_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              step,
    output logic [PRBS_W-1:0] state
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    state <= PRBS_SEED;
        else if (step) state <= prbs31_next(state);
    end
endmodule

// File: rtl/axis_pattern_gen.sv
// AXI-Stream packet generator: ramp payload, optional PRBS-31 payload when
// AXIS_PATTERN_GEN_PRBS_EN is defined (adds the mode input).
module axis_pattern_gen
    import axis_pattern_gen_pkg::*;
#(
    parameter int unsigned BUS_WIDTH  = 2,
    parameter int unsigned USER_WIDTH = 1,
    parameter int unsigned DEST_WIDTH = 1,
    parameter int unsigned PKT_LEN    = 16,
    parameter int unsigned GAP        = 0,
    parameter int unsigned STEP       = 1
) (
    input  logic              aclk,
    input  logic              arstn,
    input  logic              en,
    input  logic [PKTS_W-1:0] pkts,
`ifdef AXIS_PATTERN_GEN_PRBS_EN
    input  logic              mode,
`endif
    output logic              done,
    axis_pattern_gen_if.master m_axis
);
    localparam int unsigned DW = BUS_WIDTH * 8;
    localparam int unsigned BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [BW-1:0]         BEAT_LAST     = BW'(PKT_LEN - 1);
    localparam logic [GW-1:0]         GAP_LAST      = GW'((GAP != 0) ? GAP - 1 : 0);
    localparam logic                  LAST_ON_FIRST = (PKT_LEN == 1);
    localparam logic [USER_WIDTH-1:0] USER_FIRST    = USER_WIDTH'(1);

    state_t                state_q;
    logic [DW-1:0]         tdata_q;
    logic [BUS_WIDTH-1:0]  tkeep_q;
    logic                  tvalid_q;
    logic                  tlast_q;
    logic [USER_WIDTH-1:0] tuser_q;
    logic [DEST_WIDTH-1:0] tdest_q;
    logic [BW-1:0]         beat_q;
    logic [GW-1:0]         gap_q;
    logic [PKTS_W-1:0]     pkt_q;
    logic [PKTS_W-1:0]     pkts_q;
    logic [DW-1:0]         ramp_q;

    logic              accept;
    logic              ramp_step;
    logic [DW-1:0]     ramp_nx;
    logic [PKTS_W-1:0] pkt_nx;
    logic [DW-1:0]     start_data;
    logic [DW-1:0]     resume_data;
    logic [DW-1:0]     next_data;

    assign accept  = tvalid_q & m_axis.tready;
    assign ramp_nx = ramp_q + DW'(STEP);
    assign pkt_nx  = pkt_q + PKTS_W'(1);

`ifdef AXIS_PATTERN_GEN_PRBS_EN
    logic              mode_q;
    logic [PRBS_W-1:0] prbs_state;

    // Truncate or replicate the 31-bit state across the data bus.
    function automatic logic [DW-1:0] prbs_fmt(input logic [PRBS_W-1:0] s);
        logic [DW-1:0] d;
        d = '0;
        for (int unsigned i = 0; i < DW; i++) d[i] = s[i % PRBS_W];
        return d;
    endfunction

    axis_pattern_gen_lfsr u_lfsr (
        .clk   (aclk),
        .rst_n (arstn),
        .step  (accept & mode_q),
        .state (prbs_state)
    );

    // start_data sees the live mode input because mode is latched on that same edge.
    assign ramp_step   = accept & ~mode_q;
    assign start_data  = mode   ? prbs_fmt(prbs_state) : ramp_q;
    assign resume_data = mode_q ? prbs_fmt(prbs_state) : ramp_q;
    assign next_data   = mode_q ? prbs_fmt(prbs31_next(prbs_state)) : ramp_nx;

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn)                        mode_q <= 1'b0;
        else if (state_q == ST_IDLE && en) mode_q <= mode;
    end
`else
    assign ramp_step   = accept;
    assign start_data  = ramp_q;
    assign resume_data = ramp_q;
    assign next_data   = ramp_nx;
`endif

    // Ramp holds the value of the beat currently presented (or next to be presented).
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn)         ramp_q <= '0;
        else if (ramp_step) ramp_q <= ramp_nx;
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            state_q  <= ST_IDLE;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tuser_q  <= '0;
            tdest_q  <= '0;
            beat_q   <= '0;
            gap_q    <= '0;
            pkt_q    <= '0;
            pkts_q   <= '0;
            done     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (en) begin
                        state_q  <= ST_SEND;
                        pkts_q   <= pkts;
                        pkt_q    <= '0;
                        beat_q   <= '0;
                        tvalid_q <= 1'b1;
                        tdata_q  <= start_data;
                        tkeep_q  <= '1;
                        tlast_q  <= LAST_ON_FIRST;
                        tuser_q  <= USER_FIRST;
                        tdest_q  <= '0;
                    end
                end
                ST_SEND: begin
                    if (accept && tlast_q) begin
                        // End of packet: stop, pause, gap, or run straight into the next one.
                        if (pkts_q != '0 && pkt_nx == pkts_q) begin
                            state_q  <= ST_DONE;
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                            tuser_q  <= '0;
                            done     <= 1'b1;
                        end else if (!en) begin
                            state_q  <= ST_IDLE;
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                            tuser_q  <= '0;
                        end else if (GAP != 0) begin
                            state_q  <= ST_GAP;
                            gap_q    <= '0;
                            pkt_q    <= pkt_nx;
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                            tuser_q  <= '0;
                        end else begin
                            pkt_q    <= pkt_nx;
                            beat_q   <= '0;
                            tdata_q  <= next_data;
                            tlast_q  <= LAST_ON_FIRST;
                            tuser_q  <= USER_FIRST;
                            tdest_q  <= DEST_WIDTH'(pkt_nx);
                        end
                    end else if (accept) begin
                        beat_q  <= BW'(beat_q + 1'b1);
                        tdata_q <= next_data;
                        tlast_q <= (BW'(beat_q + 1'b1) == BEAT_LAST);
                        tuser_q <= '0;
                    end
                end
                ST_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        state_q  <= ST_SEND;
                        beat_q   <= '0;
                        tvalid_q <= 1'b1;
                        tdata_q  <= resume_data;
                        tkeep_q  <= '1;
                        tlast_q  <= LAST_ON_FIRST;
                        tuser_q  <= USER_FIRST;
                        tdest_q  <= DEST_WIDTH'(pkt_q);
                    end else begin
                        gap_q <= GW'(gap_q + 1'b1);
                    end
                end
                ST_DONE: begin
                    if (!en) begin
                        state_q <= ST_IDLE;
                        done    <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign m_axis.tdata  = tdata_q;
    assign m_axis.tkeep  = tkeep_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;
    assign m_axis.tuser  = tuser_q;
    assign m_axis.tdest  = tdest_q;

endmodule

// File: doc/axis_pattern_gen.md
AXIS_PATTERN_GEN -- requirements
Module: axis_pattern_gen

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 2: tdata width in bytes; tdata is BUS_WIDTH*8 bits.
REQ-002 SHALL have parameter USER_WIDTH, default 1: tuser width.
REQ-003 SHALL have parameter DEST_WIDTH, default 1: tdest width.
REQ-004 SHALL have parameter PKT_LEN, default 16: beats per packet, legal range 1 or more.
REQ-005 SHALL have parameter GAP, default 0: idle cycles between packets, legal range 0 or more.
REQ-006 SHALL have parameter STEP, default 1: ramp increment per accepted beat.
REQ-007 SHALL have port aclk  in  1  the single clock.
REQ-008 SHALL have port arstn  in  1  reset, asynchronous and active-low.
REQ-009 SHALL have port en  in  1  run request.
REQ-010 SHALL have port pkts  in  16  packets to send per run; 0 means continuous.
REQ-011 SHALL have port done  out  1  run complete.
REQ-012 SHALL have ports m_axis_tdata out BUS_WIDTH*8, m_axis_tvalid out 1, m_axis_tready in 1, m_axis_tkeep out BUS_WIDTH, m_axis_tlast out 1, m_axis_tuser out USER_WIDTH, m_axis_tdest out DEST_WIDTH: AXIS master.

Function
REQ-013 SHALL implement states IDLE, SEND, GAP and DONE.
REQ-014 SHALL move IDLE->SEND on the first aclk edge with en=1; tvalid SHALL rise that same edge.
REQ-015 SHALL hold tdata/tkeep/tlast/tuser/tdest stable and tvalid high while tready=0; a beat is accepted only when tvalid&tready.
REQ-016 SHALL produce a ramp: first beat after reset = 0; each accepted beat adds STEP modulo 2^(BUS_WIDTH*8); the ramp continues across packets and runs.
REQ-017 SHALL drive tkeep all ones on every beat.
REQ-018 SHALL assert tlast on beat PKT_LEN-1 of each packet; if PKT_LEN=1, on every beat.
REQ-019 SHALL set tuser bit 0 on beat 0 of each packet; all other tuser bits SHALL be 0.
REQ-020 SHALL set tdest = low DEST_WIDTH bits of the packet index within the run (first packet = 0).
REQ-021 SHALL act on acceptance of a tlast beat as follows:
- if pkts!=0 and the packet count equals pkts -> DONE;
- else if en=0 -> IDLE;
- else if GAP>0 -> GAP (tvalid=0 for exactly GAP cycles, then SEND);
- else remain in SEND with no bubble.
REQ-022 SHALL NOT truncate a packet when en falls mid-packet.
REQ-023 SHALL assert done=1 in DONE and return to IDLE when en=0.
REQ-024 SHALL sample pkts on the IDLE->SEND transition only.
REQ-025 SHALL drive all outputs from registers, with no combinational path from tready to tvalid.

Reset
REQ-026 SHALL, when arstn=0, immediately force state IDLE, ramp 0, all beat/packet counters 0, and tvalid, tlast, tdata, tkeep, tuser, tdest and done all 0.
REQ-027 SHALL abandon any packet in progress at reset; after release, the first beat SHALL carry tdata 0 and tuser=1.

Configuration
REQ-028 SHALL, with AXIS_PATTERN_GEN_PRBS_EN defined, add input port mode (1 bit; 0 = ramp, 1 = PRBS), sampled on IDLE->SEND.
REQ-029 In PRBS mode, tdata SHALL come from a PRBS-31 generator (x^31+x^28+1), seeded all-ones at reset and advancing one step per accepted beat; the state is truncated or replicated to BUS_WIDTH*8 bits.
REQ-030 SHALL, without AXIS_PATTERN_GEN_PRBS_EN, have no mode port, no PRBS logic, and ramp data only.

Structure
REQ-031 SHALL place the state encodings and the PRBS-31 polynomial/seed constants in shared package axis_pattern_gen_pkg.
REQ-032 SHALL implement the PRBS in sub-module axis_pattern_gen_lfsr (step enable input, parallel state output), instantiated only under AXIS_PATTERN_GEN_PRBS_EN.

Verification
All scenarios use BUS_WIDTH=2, PKT_LEN=4, GAP=2, STEP=1 unless stated otherwise.
REQ-033 Basic run: en=1, pkts=2, tready=1 -> tdata 0x0000..0x0007; tlast on 0x0003 and 0x0007; tuser on 0x0000 and 0x0004; tdest 0 then 1; 2 idle cycles between packets; then done=1.
REQ-034 Back-pressure: tready=0 for 3 cycles while beat 0x0002 is presented -> tvalid stays high, tdata holds 0x0002, no beat is lost or duplicated.
REQ-035 Wrap-around: STEP=0x4000 -> beats 0x0000, 0x4000, 0x8000, 0xC000, 0x0000.
REQ-036 Early stop: pkts=0, en dropped during beat 1 -> beats 2 and 3 still sent, tlast on beat 3, then tvalid=0 and state IDLE.
REQ-037 Mid-packet reset: arstn low during beat 2 -> tvalid falls without waiting for an aclk edge; after release and en=1, first beat is 0x0000 with tuser=1.
REQ-038 PRBS mode (macro defined): mode=1 -> first 8 beats match a golden PRBS-31 model seeded all-ones, with back-pressure applied.
